// File: rtl/adpll_gain_scheduler.sv
// ---------------------------------------------------------------------------
// adpll_gain_scheduler
// Acquisition/lock controller for one network ADPLL node. Samples the
// combined phase error once per divided generated-clock period and selects
// wide acquisition or narrow tracking gains for the loop filter. It also
// declares lock, detects loss of lock and flags acquisition timeouts.
//
// Ports
//   fpga_clk_i  : system clock, all logic on the rising edge
//   reset_i     : asynchronous active-low reset
//   enable_i    : level enable; low forces IDLE on the next edge
//   gen_div8_i  : divided generated clock (asynchronous sampling reference)
//   error_i     : signed combined phase error
//   kp_o/ki_o   : registered loop filter gains
//   locked_o    : high only in LOCKED
//   state_o     : IDLE=0, ACQUIRE=1, SETTLE=2, LOCKED=3
//   acq_fail_o  : sticky acquisition-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module adpll_gain_scheduler #(
  parameter int PDET_WIDTH    = 8,
  parameter int KP_WIDTH      = 3,
  parameter int KI_WIDTH      = 4,
  parameter logic [KP_WIDTH-1:0] KP_ACQ = 3'b100,
  parameter logic [KI_WIDTH-1:0] KI_ACQ = 4'b0100,
  parameter logic [KP_WIDTH-1:0] KP_TRK = 3'b010,
  parameter logic [KI_WIDTH-1:0] KI_TRK = 4'b0001,
  parameter int LOCK_THRESH   = 2,
  parameter int UNLOCK_THRESH = 8,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int ACQ_TIMEOUT   = 1024,
  parameter int CNT_WIDTH     = 11
) (
  input  logic                         fpga_clk_i,
  input  logic                         reset_i,
  input  logic                         enable_i,
  input  logic                         gen_div8_i,
  input  logic signed [PDET_WIDTH-1:0] error_i,
  output logic        [KP_WIDTH-1:0]   kp_o,
  output logic        [KI_WIDTH-1:0]   ki_o,
  output logic                         locked_o,
  output logic        [1:0]            state_o,
  output logic                         acq_fail_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_SETTLE = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LC_LAST = CNT_WIDTH'(LOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] UC_LAST = CNT_WIDTH'(UNLOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LIM  = CNT_WIDTH'(ACQ_TIMEOUT);

  // |v| with the most negative code saturated to the largest positive code.
  function automatic logic [PDET_WIDTH-1:0] sat_abs(input logic signed [PDET_WIDTH-1:0] v);
    if (v == {1'b1, {(PDET_WIDTH-1){1'b0}}})
      sat_abs = {1'b0, {(PDET_WIDTH-1){1'b1}}};
    else if (v < 0)
      sat_abs = $unsigned(-v);
    else
      sat_abs = $unsigned(v);
  endfunction

  state_t                r_state, w_state_nxt;
  logic                  r_sync1, r_sync2, r_sync3;
  logic [CNT_WIDTH-1:0]  r_run_cnt, w_run_nxt;
  logic [CNT_WIDTH-1:0]  r_to_cnt, w_to_nxt;
  logic                  r_fail, w_fail_nxt;
  logic [KP_WIDTH-1:0]   r_kp, w_kp_nxt;
  logic [KI_WIDTH-1:0]   r_ki, w_ki_nxt;
  logic                  r_locked;
  logic                  w_strobe;
  logic [PDET_WIDTH-1:0] w_mag;
  logic                  w_in, w_out;
  logic [CNT_WIDTH-1:0]  w_to_inc;

  // Stage boundary: two-flop synchroniser plus edge-history flop; the strobe
  // is high for the one cycle where the synchronised level has just risen.
  assign w_strobe = r_sync2 & ~r_sync3;
  assign w_mag    = sat_abs(error_i);
  assign w_in     = (w_mag <= PDET_WIDTH'(LOCK_THRESH));
  assign w_out    = (w_mag >  PDET_WIDTH'(UNLOCK_THRESH));
  assign w_to_inc = r_to_cnt + CNT_WIDTH'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_cnt;
    w_to_nxt    = r_to_cnt;
    w_fail_nxt  = r_fail;
    if (!enable_i) begin
      w_state_nxt = S_IDLE;
      w_run_nxt   = '0;
      w_to_nxt    = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ACQ;
          w_run_nxt   = '0;
          w_to_nxt    = '0;
        end
        S_ACQ: if (w_strobe) begin
          if (w_in && r_run_cnt == LC_LAST) begin
            // Promotion beats a coincident timeout.
            w_state_nxt = S_SETTLE;
            w_run_nxt   = '0;
            w_to_nxt    = '0;
          end else begin
            w_run_nxt = w_in ? r_run_cnt + CNT_WIDTH'(1) : '0;
            if (w_to_inc == TO_LIM) begin
              w_fail_nxt = 1'b1;
              w_to_nxt   = '0;
            end else begin
              w_to_nxt = w_to_inc;
            end
          end
        end
        S_SETTLE: if (w_strobe) begin
          if (!w_in) begin
            w_state_nxt = S_ACQ;
            w_run_nxt   = '0;
            w_to_nxt    = '0;
          end else if (r_run_cnt == LC_LAST) begin
            w_state_nxt = S_LOCKED;
            w_run_nxt   = '0;
            w_to_nxt    = '0;
          end else begin
            w_run_nxt = r_run_cnt + CNT_WIDTH'(1);
          end
        end
        S_LOCKED: if (w_strobe) begin
          if (!w_out) begin
            w_run_nxt = '0;
          end else if (r_run_cnt == UC_LAST) begin
            w_state_nxt = S_ACQ;
            w_run_nxt   = '0;
            w_to_nxt    = '0;
          end else begin
            w_run_nxt = r_run_cnt + CNT_WIDTH'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Gains follow the next state so they change on the same edge as state_o.
    w_kp_nxt = '0;
    w_ki_nxt = '0;
    unique case (w_state_nxt)
      S_ACQ:              begin w_kp_nxt = KP_ACQ; w_ki_nxt = KI_ACQ; end
      S_SETTLE, S_LOCKED: begin w_kp_nxt = KP_TRK; w_ki_nxt = KI_TRK; end
      default:            begin w_kp_nxt = '0;     w_ki_nxt = '0;     end
    endcase
  end

  // Stage boundary: state, counters and registered outputs.
  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_state   <= S_IDLE;
      r_run_cnt <= '0;
      r_to_cnt  <= '0;
      r_fail    <= 1'b0;
      r_kp      <= '0;
      r_ki      <= '0;
      r_locked  <= 1'b0;
    end else begin
      r_sync1   <= gen_div8_i;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_nxt;
      r_to_cnt  <= w_to_nxt;
      r_fail    <= w_fail_nxt;
      r_kp      <= w_kp_nxt;
      r_ki      <= w_ki_nxt;
      r_locked  <= (w_state_nxt == S_LOCKED);
    end
  end

  assign kp_o       = r_kp;
  assign ki_o       = r_ki;
  assign locked_o   = r_locked;
  assign state_o    = r_state;
  assign acq_fail_o = r_fail;

endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adpll_gain_scheduler
// Directed bench for adpll_gain_scheduler. Stimulus pushes hand-computed
// expected output snapshots into a scoreboard queue, each tagged with the
// cycle at which it applies; a monitor on the falling clock edge pops and
// compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_adpll_gain_scheduler;

  logic              fpga_clk_i = 1'b0;
  logic              reset_i    = 1'b0;
  logic              enable_i   = 1'b0;
  logic              gen_div8_i = 1'b0;
  logic signed [7:0] error_i    = '0;
  logic [2:0]        kp_o;
  logic [3:0]        ki_o;
  logic              locked_o;
  logic [1:0]        state_o;
  logic              acq_fail_o;

  adpll_gain_scheduler dut (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .gen_div8_i (gen_div8_i),
    .error_i    (error_i),
    .kp_o       (kp_o),
    .ki_o       (ki_o),
    .locked_o   (locked_o),
    .state_o    (state_o),
    .acq_fail_o (acq_fail_o)
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  int cyc = 0;
  always @(posedge fpga_clk_i) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [1:0] st;
    logic [2:0] kp;
    logic [3:0] ki;
    logic       lk;
    logic       fl;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Expected snapshot {state, kp, ki, locked, acq_fail} for the current cycle.
  task automatic expect_out(input logic [1:0] st, input logic [2:0] kp, input logic [3:0] ki,
                            input logic lk, input logic fl, input string name);
    exp_t e;
    e.due = cyc; e.st = st; e.kp = kp; e.ki = ki; e.lk = lk; e.fl = fl; e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge fpga_clk_i) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      logic [10:0] act, req;
      e   = sb.pop_front();
      act = {state_o, kp_o, ki_o, locked_o, acq_fail_o};
      req = {e.st, e.kp, e.ki, e.lk, e.fl};
      n_tests++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL %s: got st=%0d kp=%b ki=%b lk=%b fail=%b, want st=%0d kp=%b ki=%b lk=%b fail=%b",
                 e.name, state_o, kp_o, ki_o, locked_o, acq_fail_o, e.st, e.kp, e.ki, e.lk, e.fl);
      end
    end
  end

  // Low half-period, then raise gen_div8_i with the new error value; returns
  // 1 time unit after the edge that makes the strobe visible (strobe cycle).
  task automatic strobe_begin(input logic signed [7:0] err);
    @(posedge fpga_clk_i); #1 gen_div8_i = 1'b0;
    repeat (3) @(posedge fpga_clk_i);
    #1 error_i = err; gen_div8_i = 1'b1;
    @(posedge fpga_clk_i);
    @(posedge fpga_clk_i); #1;
  endtask

  // Edge that ends the strobe cycle; outputs reflect the sample afterwards.
  task automatic strobe_end();
    @(posedge fpga_clk_i); #1;
  endtask

  task automatic sample(input logic signed [7:0] err);
    strobe_begin(err);
    strobe_end();
  endtask

  localparam logic [1:0] IDLE = 2'd0, ACQ = 2'd1, SET = 2'd2, LCK = 2'd3;

  initial begin
    logic signed [7:0] lk_vec [8];
    lk_vec = '{8'sd9, 8'sd9, 8'sd9, 8'sd5, 8'sd9, 8'sd9, 8'sd9, 8'sd9};

    // Reset state.
    repeat (3) @(posedge fpga_clk_i);
    #1 expect_out(IDLE, 3'b000, 4'b0000, 1'b0, 1'b0, "reset");
    @(posedge fpga_clk_i); #1 reset_i = 1'b1;
    @(posedge fpga_clk_i); #1 expect_out(IDLE, 3'b000, 4'b0000, 1'b0, 1'b0, "idle_disabled");

    // Enable with no gen edges: ACQUIRE one cycle later and held.
    enable_i = 1'b1;
    @(posedge fpga_clk_i); #1 expect_out(ACQ, 3'b100, 4'b0100, 1'b0, 1'b0, "enable_acq");
    repeat (20) @(posedge fpga_clk_i);
    #1 expect_out(ACQ, 3'b100, 4'b0100, 1'b0, 1'b0, "stall_hold");

    // 16 in-window samples to SETTLE, 16 more to LOCKED.
    for (int i = 1; i <= 16; i++) begin
      sample(8'sd1);
      if (i == 15) expect_out(ACQ, 3'b100, 4'b0100, 1'b0, 1'b0, "acq_after15");
    end
    expect_out(SET, 3'b010, 4'b0001, 1'b0, 1'b0, "settle_after16");
    for (int i = 1; i <= 16; i++) begin
      strobe_begin(8'sd1);
      if (i == 16) expect_out(SET, 3'b010, 4'b0001, 1'b0, 1'b0, "settle_before_lock");
      strobe_end();
    end
    expect_out(LCK, 3'b010, 4'b0001, 1'b1, 1'b0, "locked_after32");

    // LOCKED: 9,9,9,5,9,9,9,9 -> the 5 breaks the run, drop on the 8th.
    for (int i = 0; i < 8; i++) begin
      sample(lk_vec[i]);
      if (i == 6) expect_out(LCK, 3'b010, 4'b0001, 1'b1, 1'b0, "locked_after7");
    end
    expect_out(ACQ, 3'b100, 4'b0100, 1'b0, 1'b0, "unlock_after8");

    // ACQUIRE: 15x2, one 3 (middle, clears run), 16x-2.
    for (int i = 0; i < 15; i++) sample(8'sd2);
    sample(8'sd3);
    expect_out(ACQ, 3'b100, 4'b0100, 1'b0, 1'b0, "middle_no_promote");
    for (int i = 1; i <= 16; i++) begin
      sample(-8'sd2);
      if (i == 15) expect_out(ACQ, 3'b100, 4'b0100, 1'b0, 1'b0, "run_was_reset");
    end
    expect_out(SET, 3'b010, 4'b0001, 1'b0, 1'b0, "settle_neg2");

    // To LOCKED, then -128 saturates to 127 (out): drop after 4.
    for (int i = 0; i < 16; i++) sample(8'sd0);
    expect_out(LCK, 3'b010, 4'b0001, 1'b1, 1'b0, "relocked");
    for (int i = 1; i <= 4; i++) begin
      sample(-8'sd128);
      if (i == 3) expect_out(LCK, 3'b010, 4'b0001, 1'b1, 1'b0, "neg128_after3");
    end
    expect_out(ACQ, 3'b100, 4'b0100, 1'b0, 1'b0, "neg128_unlock");

    // Acquisition timeout after 1024 strobes of a non-qualifying error.
    for (int i = 1; i <= 1024; i++) begin
      sample(8'sd50);
      if (i == 1023) expect_out(ACQ, 3'b100, 4'b0100, 1'b0, 1'b0, "no_timeout_1023");
    end
    expect_out(ACQ, 3'b100, 4'b0100, 1'b0, 1'b1, "timeout_1024");
    enable_i = 1'b0;
    @(posedge fpga_clk_i); #1 expect_out(IDLE, 3'b000, 4'b0000, 1'b0, 1'b1, "disable_keeps_fail");
    enable_i = 1'b1;
    @(posedge fpga_clk_i); #1 expect_out(ACQ, 3'b100, 4'b0100, 1'b0, 1'b1, "reenable_fail_sticky");

    // Lock again, then assert reset between clock edges.
    for (int i = 0; i < 32; i++) sample(-8'sd1);
    expect_out(LCK, 3'b010, 4'b0001, 1'b1, 1'b1, "locked_before_reset");
    @(posedge fpga_clk_i); #2 reset_i = 1'b0;
    #1 expect_out(IDLE, 3'b000, 4'b0000, 1'b0, 1'b0, "async_reset");

    for (int k = 0; k < 100 && sb.size() > 0; k++) @(posedge fpga_clk_i);
    @(negedge fpga_clk_i); #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
